// File: rtl/fb_bank_sched_if.sv
// -----------------------------------------------------------------------------
// fb_bank_sched_if
// Handshake bundle between the ping-pong frame-bank scheduler and its two
// clients (the capture writer and the BRAM-to-FIFO reader).
//
// Signals:
//   i_wr_frame_start  writer -> sched  pulse: writer begins a frame
//   i_wr_frame_done   writer -> sched  pulse: last pixel of the frame written
//   o_wr_bank         sched  -> writer bank the writer must address
//   o_wr_en           sched  -> writer writer may write
//   o_rd_req          sched  -> reader held read request
//   o_rd_bank         sched  -> reader bank the reader must address
//   i_rd_done         reader -> sched  pulse: reader issued its last address
//   o_frame_drop      sched  -> any    one-cycle pulse per discarded frame
//   o_drop_cnt        sched  -> any    saturating dropped-frame count
//
// Modports: master = scheduler side, slave = writer/reader side.
// -----------------------------------------------------------------------------
interface fb_bank_sched_if #(
  parameter int CNT_W = 16
);
  logic             i_wr_frame_start;
  logic             i_wr_frame_done;
  logic             o_wr_bank;
  logic             o_wr_en;
  logic             o_rd_req;
  logic             o_rd_bank;
  logic             i_rd_done;
  logic             o_frame_drop;
  logic [CNT_W-1:0] o_drop_cnt;

  modport master (
    input  i_wr_frame_start, i_wr_frame_done, i_rd_done,
    output o_wr_bank, o_wr_en, o_rd_req, o_rd_bank, o_frame_drop, o_drop_cnt
  );

  modport slave (
    output i_wr_frame_start, i_wr_frame_done, i_rd_done,
    input  o_wr_bank, o_wr_en, o_rd_req, o_rd_bank, o_frame_drop, o_drop_cnt
  );
endinterface

// File: rtl/fb_bank_sched.sv
// -----------------------------------------------------------------------------
// fb_bank_sched
// Ping-pong scheduler for two BRAM frame banks shared by a capture writer and a
// BRAM-to-FIFO reader. Tracks per-bank ownership, steers the writer to a bank,
// issues held read requests for completed frames, and drops a stale frame when
// the writer would otherwise collide with the bank being read.
//
// Ports:
//   i_clk   single clock
//   i_rst   synchronous reset, active-high (also resets the external reader)
//   bus     fb_bank_sched_if.master (writer/reader handshake, drop reporting)
//
// Parameters:
//   REQ_HOLD  cycles o_rd_req stays high per request (>= 3 for the reader's
//             two-flop synchronizer)
//   CNT_W     width of the dropped-frame counter
//
// Optional feature (macro FB_REPEAT_EN): when no new frame is ready, re-request
// the most recently completed read bank so the display repeats the last frame.
// -----------------------------------------------------------------------------
module fb_bank_sched #(
  parameter int REQ_HOLD = 4,
  parameter int CNT_W    = 16
) (
  input logic           i_clk,
  input logic           i_rst,
  fb_bank_sched_if.master bus
);

  localparam int HOLD_W = $clog2(REQ_HOLD + 1);

  typedef enum logic [1:0] {
    B_FREE    = 2'd0,
    B_WRITING = 2'd1,
    B_READY   = 2'd2,
    B_READING = 2'd3
  } bank_st_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_REQ  = 2'd1,
    R_WAIT = 2'd2
  } rd_st_e;

  bank_st_e    bank_st [2];
  bank_st_e    st_n    [2];
  logic        last_wr;
  logic        lw_n;
  rd_st_e      r_state;
  logic [HOLD_W-1:0] hold_cnt;

  logic        claim_vld;
  logic        claim_bank;
  logic        cand;
  logic        drop;
  logic        rdy0;
  logic        rdy1;
  logic        sel_vld;
  logic        sel_bank;

`ifdef FB_REPEAT_EN
  logic        last_rd;
  logic        rep_vld;
`endif

  // ---------------------------------------------------------------------------
  // Next bank ownership. Order of application: writer done, writer claim,
  // reader release, reader select.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable written here gets a default first so no latch is
    // inferred; combinational blocks use blocking '=' so later lines see the
    // updated values within the same evaluation.
    st_n       = bank_st;
    lw_n       = last_wr;
    claim_vld  = 1'b0;
    claim_bank = 1'b0;
    cand       = 1'b0;
    drop       = 1'b0;
    sel_vld    = 1'b0;
    sel_bank   = 1'b0;

    // Writer completion first, so a same-cycle start sees the finished frame.
    if (bus.i_wr_frame_done) begin
      if (bank_st[0] == B_WRITING) begin
        st_n[0] = B_READY;
        lw_n    = 1'b0;
      end else if (bank_st[1] == B_WRITING) begin
        st_n[1] = B_READY;
        lw_n    = 1'b1;
      end
    end

    if (bus.i_wr_frame_start) begin
      claim_vld = 1'b1;
      if (st_n[0] == B_WRITING || st_n[1] == B_WRITING) begin
        // Restart: the partial frame in the same bank is discarded.
        claim_bank = (st_n[1] == B_WRITING);
        drop       = 1'b1;
      end else begin
        // READING is judged on pre-update state so a same-cycle rd_done
        // cannot hand the writer the bank still being streamed out.
        cand       = ~lw_n;
        claim_bank = (bank_st[cand] == B_READING) ? lw_n : cand;
        drop       = (st_n[claim_bank] == B_READY);
      end
      st_n[claim_bank] = B_WRITING;
    end

    if (r_state == R_WAIT && bus.i_rd_done)
      st_n[bus.o_rd_bank] = B_FREE;

    // Reader selection uses registered state (one cycle of READY visibility)
    // and skips a bank the writer is grabbing this cycle.
    rdy0 = (bank_st[0] == B_READY) && !(claim_vld && claim_bank == 1'b0);
    rdy1 = (bank_st[1] == B_READY) && !(claim_vld && claim_bank == 1'b1);
    if (rdy0 && rdy1) begin
      sel_vld  = 1'b1;
      sel_bank = last_wr;
    end else if (rdy0 || rdy1) begin
      sel_vld  = 1'b1;
      sel_bank = rdy1;
    end
`ifdef FB_REPEAT_EN
    else if (rep_vld && bank_st[last_rd] == B_FREE &&
             !(claim_vld && claim_bank == last_rd)) begin
      sel_vld  = 1'b1;
      sel_bank = last_rd;
    end
`endif

    if (r_state == R_IDLE && sel_vld)
      st_n[sel_bank] = B_READING;
  end

  // ---------------------------------------------------------------------------
  // State registers, reader FSM and registered outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // NOTE: the two-entry ownership table is ordinary control state, not a
      // RAM, so it is reset along with everything else.
      bank_st          <= '{B_FREE, B_FREE};
      last_wr          <= 1'b1;
      r_state          <= R_IDLE;
      hold_cnt         <= '0;
      bus.o_wr_bank    <= 1'b0;
      bus.o_wr_en      <= 1'b0;
      bus.o_rd_req     <= 1'b0;
      bus.o_rd_bank    <= 1'b0;
      bus.o_frame_drop <= 1'b0;
      bus.o_drop_cnt   <= '0;
`ifdef FB_REPEAT_EN
      last_rd          <= 1'b0;
      rep_vld          <= 1'b0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking '<=' so every register
      // samples pre-edge values regardless of statement order.
      bank_st          <= st_n;
      last_wr          <= lw_n;
      bus.o_wr_en      <= (st_n[0] == B_WRITING) || (st_n[1] == B_WRITING);
      bus.o_frame_drop <= drop;
      if (claim_vld)
        bus.o_wr_bank <= claim_bank;
      if (drop && bus.o_drop_cnt != {CNT_W{1'b1}})
        bus.o_drop_cnt <= bus.o_drop_cnt + 1'b1;

`ifdef FB_REPEAT_EN
      // A writer claim on the remembered bank invalidates its contents.
      if (claim_vld && claim_bank == last_rd)
        rep_vld <= 1'b0;
`endif

      case (r_state)
        R_IDLE: begin
          if (sel_vld) begin
            bus.o_rd_bank <= sel_bank;
            bus.o_rd_req  <= 1'b1;
            hold_cnt      <= HOLD_W'(1);
            r_state       <= R_REQ;
          end
        end
        R_REQ: begin
          if (hold_cnt == HOLD_W'(REQ_HOLD)) begin
            bus.o_rd_req <= 1'b0;
            r_state      <= R_WAIT;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        R_WAIT: begin
          if (bus.i_rd_done) begin
            r_state <= R_IDLE;
`ifdef FB_REPEAT_EN
            last_rd <= bus.o_rd_bank;
            rep_vld <= 1'b1;
`endif
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_bank_sched.sv
// -----------------------------------------------------------------------------
// tb_fb_bank_sched
// Directed bench for fb_bank_sched: reset state, basic write/read hand-off,
// writer/reader overlap, stale-frame drop, writer restart, mid-request reset,
// and the FB_REPEAT_EN repeat-last-frame behaviour (or its absence).
// Inputs are driven 1 time unit after a rising edge; outputs are sampled at
// the same point, i.e. reflecting the edge just taken.
// -----------------------------------------------------------------------------
module tb_fb_bank_sched;

  localparam int CNT_W    = 16;
  localparam int REQ_HOLD = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fb_bank_sched_if #(.CNT_W(CNT_W)) bus ();

  fb_bank_sched #(
    .REQ_HOLD (REQ_HOLD),
    .CNT_W    (CNT_W)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst                  = 1'b1;
    bus.i_wr_frame_start = 1'b0;
    bus.i_wr_frame_done  = 1'b0;
    bus.i_rd_done        = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_wr_en",   bus.o_wr_en,      1'b0);
    check("rst_wr_bank", bus.o_wr_bank,    1'b0);
    check("rst_rd_req",  bus.o_rd_req,     1'b0);
    check("rst_rd_bank", bus.o_rd_bank,    1'b0);
    check("rst_drop",    bus.o_frame_drop, 1'b0);
    check("rst_cnt",     32'(bus.o_drop_cnt), 32'd0);
    rst = 1'b0;
    tick();

    // First frame goes to bank 0
    bus.i_wr_frame_start = 1'b1; tick(); bus.i_wr_frame_start = 1'b0;
    check("f1_wr_bank", bus.o_wr_bank, 1'b0);
    check("f1_wr_en",   bus.o_wr_en,   1'b1);
    tick(); tick();
    check("f1_wr_en_mid", bus.o_wr_en,  1'b1);
    check("f1_no_req",    bus.o_rd_req, 1'b0);
    bus.i_wr_frame_done = 1'b1; tick(); bus.i_wr_frame_done = 1'b0;
    check("f1_wr_en_off", bus.o_wr_en,  1'b0);
    check("f1_req_lat1",  bus.o_rd_req, 1'b0);
    tick();
    check("f1_req_rise",  bus.o_rd_req,  1'b1);
    check("f1_rd_bank",   bus.o_rd_bank, 1'b0);
    // rd_done during the request phase must be ignored
    bus.i_rd_done = 1'b1; tick(); bus.i_rd_done = 1'b0;
    check("f1_req_2", bus.o_rd_req, 1'b1);
    tick();
    check("f1_req_3", bus.o_rd_req, 1'b1);
    tick();
    check("f1_req_4", bus.o_rd_req, 1'b1);
    tick();
    check("f1_req_fall", bus.o_rd_req, 1'b0);

    // Bank 0 READING: writer gets bank 1
    bus.i_wr_frame_start = 1'b1; tick(); bus.i_wr_frame_start = 1'b0;
    check("f2_wr_bank", bus.o_wr_bank,    1'b1);
    check("f2_wr_en",   bus.o_wr_en,      1'b1);
    check("f2_no_drop", bus.o_frame_drop, 1'b0);
    bus.i_wr_frame_done = 1'b1; tick(); bus.i_wr_frame_done = 1'b0;
    check("f2_wr_en_off", bus.o_wr_en, 1'b0);
    tick();
    check("f2_reader_busy", bus.o_rd_req, 1'b0);

    // Bank 0 READING, bank 1 READY: new frame overwrites bank 1
    bus.i_wr_frame_start = 1'b1; tick(); bus.i_wr_frame_start = 1'b0;
    check("f3_wr_bank", bus.o_wr_bank,    1'b1);
    check("f3_wr_en",   bus.o_wr_en,      1'b1);
    check("f3_drop",    bus.o_frame_drop, 1'b1);
    check("f3_cnt",     32'(bus.o_drop_cnt), 32'd1);
    tick();
    check("f3_drop_pulse", bus.o_frame_drop, 1'b0);

    // Restart without done: same bank, one more drop, wr_en stays high
    bus.i_wr_frame_start = 1'b1; tick(); bus.i_wr_frame_start = 1'b0;
    check("f4_wr_bank", bus.o_wr_bank,    1'b1);
    check("f4_wr_en",   bus.o_wr_en,      1'b1);
    check("f4_drop",    bus.o_frame_drop, 1'b1);
    check("f4_cnt",     32'(bus.o_drop_cnt), 32'd2);
    bus.i_wr_frame_done = 1'b1; tick(); bus.i_wr_frame_done = 1'b0;
    check("f4_wr_en_off", bus.o_wr_en,      1'b0);
    check("f4_drop_off",  bus.o_frame_drop, 1'b0);

    // Reader releases bank 0, then picks up bank 1
    bus.i_rd_done = 1'b1; tick(); bus.i_rd_done = 1'b0;
    check("f5_req_idle", bus.o_rd_req, 1'b0);
    tick();
    check("f5_req_rise", bus.o_rd_req,  1'b1);
    check("f5_rd_bank",  bus.o_rd_bank, 1'b1);
    repeat (3) tick();
    check("f5_req_4",    bus.o_rd_req, 1'b1);
    tick();
    check("f5_req_fall", bus.o_rd_req, 1'b0);
    check("f5_cnt_hold", 32'(bus.o_drop_cnt), 32'd2);

    // Bank 1 READING: writer fills bank 0
    bus.i_wr_frame_start = 1'b1; tick(); bus.i_wr_frame_start = 1'b0;
    check("f6_wr_bank", bus.o_wr_bank, 1'b0);
    bus.i_wr_frame_done = 1'b1; tick(); bus.i_wr_frame_done = 1'b0;
    check("f6_wr_en_off", bus.o_wr_en, 1'b0);
    bus.i_rd_done = 1'b1; tick(); bus.i_rd_done = 1'b0;
    tick();
    check("f6_req_rise", bus.o_rd_req,  1'b1);
    check("f6_rd_bank",  bus.o_rd_bank, 1'b0);
    // Writer takes bank 1 while the request is held
    bus.i_wr_frame_start = 1'b1; tick(); bus.i_wr_frame_start = 1'b0;
    check("f6_wr_bank1", bus.o_wr_bank, 1'b1);
    check("f6_wr_en",    bus.o_wr_en,   1'b1);
    check("f6_req_held", bus.o_rd_req,  1'b1);

    // Reset during R_REQ
    rst = 1'b1; tick();
    check("mr_rd_req",  bus.o_rd_req,  1'b0);
    check("mr_wr_en",   bus.o_wr_en,   1'b0);
    check("mr_wr_bank", bus.o_wr_bank, 1'b0);
    check("mr_cnt",     32'(bus.o_drop_cnt), 32'd0);
    rst = 1'b0;
    bus.i_wr_frame_start = 1'b1; tick(); bus.i_wr_frame_start = 1'b0;
    check("mr_claim_bank", bus.o_wr_bank, 1'b0);
    check("mr_claim_en",   bus.o_wr_en,   1'b1);

    // One frame, read it, then no new frame
    tick();
    bus.i_wr_frame_done = 1'b1; tick(); bus.i_wr_frame_done = 1'b0;
    tick();
    check("rp_req_rise", bus.o_rd_req,  1'b1);
    check("rp_rd_bank",  bus.o_rd_bank, 1'b0);
    repeat (4) tick();
    check("rp_req_fall", bus.o_rd_req, 1'b0);
    bus.i_rd_done = 1'b1; tick(); bus.i_rd_done = 1'b0;
    check("rp_idle", bus.o_rd_req, 1'b0);
    tick();
`ifdef FB_REPEAT_EN
    check("rp_repeat_req",  bus.o_rd_req,  1'b1);
    check("rp_repeat_bank", bus.o_rd_bank, 1'b0);
`else
    check("rp_no_repeat", bus.o_rd_req, 1'b0);
    repeat (3) tick();
    check("rp_still_idle", bus.o_rd_req, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
